fsm_stream_ctrl: RTL

//  Sequencer for the bit-serial lab sequence-detector FSM (clk/rst/in/out).

---
 rtl/fsm_ctrl_pkg.sv | 22 ++
 rtl/fsm_stream_ctrl_piso_shifter.sv | 32 +++
 rtl/fsm_stream_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fsm_ctrl_pkg.sv
// Shared types and defaults for the serial sequence-detector stream controller.
package fsm_ctrl_pkg;

  localparam int DEF_WIDTH = 20;
  localparam int DEF_CNT_W = 5;
  localparam int DEF_LAT   = 1;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_CLR   = 3'd1;
  localparam logic [2:0] ENC_SHIFT = 3'd2;
  localparam logic [2:0] ENC_DRAIN = 3'd3;
  localparam logic [2:0] ENC_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_CLR   = ENC_CLR,
    ST_SHIFT = ENC_SHIFT,
    ST_DRAIN = ENC_DRAIN,
    ST_DONE  = ENC_DONE
  } state_t;

endpackage

// File: rtl/fsm_stream_ctrl_piso_shifter.sv
// Parallel-in serial-out shifter: loads a pattern, shifts left, MSB is the serial bit.
module piso_shifter
  import fsm_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sh_r;

  // Pattern register: load has priority over shift
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sh_r <= din;
    end else if (shift) begin
      sh_r <= {sh_r[WIDTH-2:0], 1'b0};
    end else begin
      sh_r <= sh_r;
    end
  end

  assign dout = sh_r[WIDTH-1];

endmodule

// File: rtl/fsm_stream_ctrl.sv
// Streams a latched pattern MSB-first into a bit-serial detector FSM and
// collects its per-bit output into a hit vector and hit count.
module fsm_stream_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_valid,
  input  logic [WIDTH-1:0] pat_data,
  output logic             pat_ready,
  input  logic             abort,
  output logic             fsm_rst,
  output logic             fsm_in,
  input  logic             fsm_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hit_vec,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int CW = $clog2(((WIDTH > LAT) ? WIDTH : LAT) + 1);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [LAT:0]     tag_r;
  logic [WIDTH-1:0] mask_r;
  logic             ser_s;
  logic             run_s;
  logic             load_s;
  logic             shift_s;
  logic             abort_s;

  // Handshake, shift enable and abort qualification
  always_comb begin
    run_s   = 1'b0;
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      ST_CLR, ST_DRAIN: run_s = 1'b1;
      ST_SHIFT: begin
        run_s   = 1'b1;
        shift_s = !abort;
      end
      ST_IDLE: load_s = pat_valid;
      default: run_s = 1'b0;
    endcase
    if (run_s && abort) begin
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

  assign pat_ready = (state_r == ST_IDLE);

  piso_shifter #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .din   (pat_data),
    .dout  (ser_s)
  );

  // Run sequencing, serial drive and hit accumulation.
  // tag_r[0] marks a valid bit on fsm_in; tag_r[LAT] marks its fsm_out sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      tag_r   <= {(LAT+1){1'b0}};
      mask_r  <= {WIDTH{1'b0}};
      fsm_rst <= 1'b1;
      fsm_in  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hit_vec <= {WIDTH{1'b0}};
      hit_cnt <= {CNT_W{1'b0}};
    end else begin
      tag_r <= abort_s ? {(LAT+1){1'b0}} : {tag_r[LAT-1:0], shift_s};
      if (tag_r[LAT]) begin
        hit_vec <= hit_vec | (mask_r & {WIDTH{fsm_out}});
        hit_cnt <= hit_cnt + {{(CNT_W-1){1'b0}}, fsm_out};
        mask_r  <= {1'b0, mask_r[WIDTH-1:1]};
      end
      if (abort_s) begin
        state_r <= ST_IDLE;
        fsm_rst <= 1'b1;
        fsm_in  <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            fsm_rst <= 1'b1;
            fsm_in  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            if (load_s) begin
              state_r <= ST_CLR;
              busy    <= 1'b1;
              hit_vec <= {WIDTH{1'b0}};
              hit_cnt <= {CNT_W{1'b0}};
              mask_r  <= {1'b1, {(WIDTH-1){1'b0}}};
              cnt_r   <= {CW{1'b0}};
            end
          end
          ST_CLR: begin
            state_r <= ST_SHIFT;
            cnt_r   <= {CW{1'b0}};
          end
          ST_SHIFT: begin
            fsm_rst <= 1'b0;
            fsm_in  <= ser_s;
            if (cnt_r == CW'(WIDTH-1)) begin
              state_r <= ST_DRAIN;
              cnt_r   <= {CW{1'b0}};
            end else begin
              cnt_r <= cnt_r + CW'(1'b1);
            end
          end
          ST_DRAIN: begin
            fsm_in <= 1'b0;
            if (cnt_r == CW'(LAT-1)) begin
              state_r <= ST_DONE;
              cnt_r   <= {CW{1'b0}};
            end else begin
              cnt_r <= cnt_r + CW'(1'b1);
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            done    <= 1'b1;
            busy    <= 1'b0;
            fsm_rst <= 1'b1;
            fsm_in  <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            fsm_rst <= 1'b1;
            fsm_in  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
